// File: rtl/mult16_pkg.sv
// Shared types for the mult16 sharing controller.
package mult16_pkg;

   localparam int OP_W = 16;
   localparam int P_W  = 32;

   typedef logic [OP_W-1:0] operand_t;
   typedef logic [P_W-1:0]  product_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      DRAIN
   } mult16_arb_state_t;

endpackage

// File: rtl/mult16_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any_gnt
);

   logic [IDX_W-1:0] idx;

   // Walk the requesters starting at ptr; the first hit wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         idx = IDX_W'((int'(ptr) + i) % N);
         if (!any_gnt && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            any_gnt  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult16_arbiter.sv
// Shares one mult16 between N_REQ requesters: round-robin grant, level
// start/done handshake with the multiplier, one shared response port.
module mult16_arbiter
   import mult16_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ID_W    = $clog2(N_REQ),
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0][15:0] req_a,
   input  logic [N_REQ-1:0][15:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_p,
   output logic                   rsp_err,
   output logic                   m_start,
   output logic [15:0]            m_a,
   output logic [15:0]            m_b,
   input  logic                   m_done,
   input  logic [31:0]            m_p,
   output logic                   busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   mult16_arb_state_t state_q, state_d;
   logic              m_start_q, m_start_d;
   operand_t          m_a_q, m_a_d, m_b_q, m_b_d;
   logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d;
   logic              rsp_valid_q, rsp_valid_d;
   product_t          rsp_p_q, rsp_p_d;
   logic              rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              any_gnt;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // Grant is only offered while idle, so a request is taken the same cycle it is granted.
   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign busy      = (state_q != IDLE);
   assign m_start   = m_start_q;
   assign m_a       = m_a_q;
   assign m_b       = m_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_p     = rsp_p_q;
   assign rsp_err   = rsp_err_q;

   // Next-state and datapath updates for the accept / wait / respond / drain cycle.
   always_comb begin
      state_d     = state_q;
      m_start_d   = m_start_q;
      m_a_d       = m_a_q;
      m_b_d       = m_b_q;
      id_d        = id_q;
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_p_d     = rsp_p_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_gnt) begin
               m_a_d     = req_a[gnt_idx];
               m_b_d     = req_b[gnt_idx];
               id_d      = gnt_idx;
               m_start_d = 1'b1;
               ptr_d     = ID_W'((int'(gnt_idx) + 1) % N_REQ);
               cnt_d     = '0;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (m_done) begin
               rsp_p_d     = m_p;
               m_start_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // Multiplier never answered: report an error with a zero product.
               rsp_p_d     = '0;
               m_start_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               // A done still high (normal tail or a late one after timeout) must fall before the next start.
               state_d     = m_done ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (!m_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         m_start_q   <= 1'b0;
         m_a_q       <= '0;
         m_b_q       <= '0;
         id_q        <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_p_q     <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         m_start_q   <= m_start_d;
         m_a_q       <= m_a_d;
         m_b_q       <= m_b_d;
         id_q        <= id_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_p_q     <= rsp_p_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mult16_arbiter.sv
// Scoreboard bench for mult16_arbiter with a registered-output mult16 model.
module tb_mult16_arbiter;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] p;
      logic        err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0][15:0] req_a;
   logic [3:0][15:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [31:0]      rsp_p;
   logic             rsp_err;
   logic             m_start;
   logic [15:0]      m_a;
   logic [15:0]      m_b;
   logic             m_done;
   logic [31:0]      m_p;
   logic             busy;

   logic             md;
   logic [31:0]      mp;
   logic             tie0, tie1;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult16_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .rsp_err   (rsp_err),
      .m_start   (m_start),
      .m_a       (m_a),
      .m_b       (m_b),
      .m_done    (m_done),
      .m_p       (m_p),
      .busy      (busy)
   );

   // mult16 model: done follows start one cycle later, product registered
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         md <= 1'b0;
         mp <= 32'h0;
      end else begin
         md <= m_start;
         if (m_start) mp <= {16'h0, m_a} * {16'h0, m_b};
      end
   end
   assign m_done = (md & ~tie0) | tie1;
   assign m_p    = mp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      chk(nm, 32'(busy), 32'h0);
   endtask

   task automatic wait_sb(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk(nm, 32'(sb.size()), 32'h0);
   endtask

   // Monitor: every response handshake pops and checks the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got id %0d p 0x%08h, expected no response", rsp_id, rsp_p);
            end else begin
               e = sb.pop_front();
               chk("rsp_id",  32'(rsp_id),  32'(e.id));
               chk("rsp_p",   rsp_p,        e.p);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Stimulus
   initial begin
      logic [31:0] prod_tab [4];
      int          acc;
      int          k;
      int          viol;
      prod_tab = '{32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC};

      rst = 1'b0; tie0 = 1'b0; tie1 = 1'b0;
      req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      repeat (2) tick();
      chk("rst_m_start",   32'(m_start),   32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      rst = 1'b1;
      tick();
      chk("rst_busy",   32'(busy),   32'h0);
      chk("rst_m_a",    32'(m_a),    32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_p",  rsp_p,       32'h0);
      chk("rst_rsp_err",32'(rsp_err),32'h0);

      // single request on requester 2
      req_a[2] = 16'h1234; req_b[2] = 16'h0010; req_valid = 4'b0100;
      #1 chk("t1_req_ready", 32'(req_ready), 32'h4);
      sb.push_back('{id: 2'd2, p: 32'h00012340, err: 1'b0});
      tick();                      // edge 0: accept
      req_valid = '0;
      chk("t1_m_start", 32'(m_start), 32'h1);
      chk("t1_m_a",     32'(m_a),     32'h1234);
      chk("t1_m_b",     32'(m_b),     32'h0010);
      chk("t1_ready0",  32'(req_ready), 32'h0);
      tick();                      // edge 1
      chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
      tick();                      // edge 2
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_m_start0",  32'(m_start),   32'h0);
      tick();                      // edge 3: taken, drain
      chk("t1_drain_busy", 32'(busy), 32'h1);
      tick();                      // edge 4
      chk("t1_idle", 32'(busy), 32'h0);

      // four requesters continuously valid, eight operations
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[i] = 16'(i + 1);
         req_b[i] = 16'hFFFF;
      end
      for (int i = 0; i < 8; i++)
         sb.push_back('{id: 2'(i % 4), p: prod_tab[i % 4], err: 1'b0});
      req_valid = 4'hF;
      acc = 0;
      #1;
      for (int c = 0; c < 200; c++) begin
         if (acc == 8) begin
            req_valid = '0;
            break;
         end
         if (req_ready != 0) begin
            chk("t2_grant_order", 32'(req_ready), 32'(1) << (acc % 4));
            acc++;
         end
         tick();
      end
      req_valid = '0;
      chk("t2_accepts", 32'(acc), 32'd8);
      wait_sb("t2_sb_drained");
      wait_idle("t2_idle");

      // backpressure with edge operands on requester 1
      rsp_ready = 1'b0;
      req_a[1] = 16'hFFFF; req_b[1] = 16'hFFFF; req_valid = 4'b0010;
      #1 chk("t3_req_ready", 32'(req_ready), 32'h2);
      sb.push_back('{id: 2'd1, p: 32'hFFFE0001, err: 1'b0});
      tick();
      req_valid = '0;
      k = 0;
      while (!rsp_valid && k < 20) begin
         tick();
         k++;
      end
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t3_rsp_p",     rsp_p,          32'hFFFE0001);
      req_valid = 4'hF;
      viol = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (rsp_id !== 2'd1 || rsp_p !== 32'hFFFE0001 || req_ready !== 4'h0 ||
             m_start !== 1'b0 || rsp_valid !== 1'b1) viol++;
      end
      chk("t3_hold_stable", 32'(viol), 32'h0);
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      chk("t3_taken", 32'(rsp_valid), 32'h0);
      chk("t3_sb_empty", 32'(sb.size()), 32'h0);
      wait_idle("t3_idle");

      // zero operand on requester 3
      req_a[3] = 16'h0000; req_b[3] = 16'hABCD; req_valid = 4'b1000;
      #1 chk("t4_req_ready", 32'(req_ready), 32'h8);
      sb.push_back('{id: 2'd3, p: 32'h0, err: 1'b0});
      tick();
      req_valid = '0;
      wait_sb("t4_sb_drained");
      wait_idle("t4_idle");

      // timeout with done held low, then a late done absorbed by drain
      tie0 = 1'b1;
      rsp_ready = 1'b0;
      req_a[0] = 16'd5; req_b[0] = 16'd7; req_valid = 4'b0001;
      #1 chk("t5_req_ready", 32'(req_ready), 32'h1);
      sb.push_back('{id: 2'd0, p: 32'h0, err: 1'b1});
      tick();
      req_valid = '0;
      chk("t5_m_start", 32'(m_start), 32'h1);
      for (k = 1; k <= 40; k++) begin
         tick();
         if (rsp_valid) break;
      end
      chk("t5_timeout_cycles", 32'(k), 32'd16);
      chk("t5_rsp_err",  32'(rsp_err), 32'h1);
      chk("t5_rsp_p",    rsp_p,        32'h0);
      chk("t5_m_start0", 32'(m_start), 32'h0);
      tie1 = 1'b1;
      rsp_ready = 1'b1;
      tick();
      chk("t5_drain_a", 32'(busy), 32'h1);
      chk("t5_taken",   32'(rsp_valid), 32'h0);
      tick();
      chk("t5_drain_b", 32'(busy), 32'h1);
      tick();
      chk("t5_drain_c", 32'(busy), 32'h1);
      tie1 = 1'b0;
      tick();
      chk("t5_idle", 32'(busy), 32'h0);
      tie0 = 1'b0;

      // asynchronous reset during WAIT
      req_a[2] = 16'd3; req_b[2] = 16'd4; req_valid = 4'b0100;
      #1 chk("t6_req_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      tick();
      chk("t6_in_wait", 32'(m_start), 32'h1);
      rst = 1'b0;
      #1;
      chk("t6_rst_m_start",   32'(m_start),   32'h0);
      chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t6_rst_busy",      32'(busy),      32'h0);
      tick();
      tick();
      rst = 1'b1;
      req_valid = 4'hF;
      #1 chk("t6_first_grant", 32'(req_ready), 32'h1);
      req_valid = '0;
      repeat (8) tick();
      chk("t6_no_stray_rsp", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
